dequantize: RTL and testbench
=============================

Name: dequantize

Overview:
- Inverse of the INT4 quantize stage.
- Reads one 16-lane INT4 row per cycle from the quantized output RAM and multiplies each lane by its latched per-lane scale factor (Q30.10).
- Streams reconstructed 40-bit Q30.10 rows to the downstream datapath (attention/matmul input).
- Processes one 64-row block per i_start.

Parameters:
- LANES, 16, number of parallel lanes
- DW, 40, reconstructed data / scale-factor width per lane (Q30.10)
- QW, 4, quantized width per lane (signed INT4)
- DEPTH, 64, rows per block
- AW, 6, RAM address width (log2 DEPTH)

Ports:
- i_clk  in  1  clock, rising edge
- i_rst_n  in  1  asynchronous active-low reset
- i_start  in  1  start a 64-row dequantize pass; sampled only in S_IDLE
- i_sf_we  in  1  latch i_sf_data into the scale-factor register
- i_sf_data  in  LANES*DW  per-lane scale factors, Q30.10 unsigned, lane k at [k*DW +: DW]
- o_ram_re  out  1  quantized RAM read enable
- o_ram_addr  out  AW  quantized RAM read address
- i_ram_data  in  LANES*QW  RAM read data, valid exactly 1 cycle after o_ram_re; lane k at [k*QW +: QW]
- o_valid  out  1  o_data/o_addr valid this cycle
- o_data  out  LANES*DW  dequantized row, Q30.10 two's complement
- o_addr  out  AW  row index of o_data
- o_done  out  1  1-cycle pulse coincident with the last o_valid of a pass
- o_busy  out  1  high in any state other than S_IDLE

Behaviour:
- Reset (async, i_rst_n low, any state including mid-pass): return to S_IDLE and clear all counters, the pipeline and the sf register to 0.
- Output values in reset: o_valid, o_done, o_busy, o_ram_re = 0; o_ram_addr, o_addr, o_data = 0.
- FSM states: S_IDLE, S_READ, S_DRAIN.
  - S_IDLE: i_start=1 -> S_READ with rd_cnt=0.
  - S_READ: o_ram_re=1, o_ram_addr=rd_cnt, rd_cnt increments each cycle. At rd_cnt==DEPTH-1 -> S_DRAIN with drain_cnt=0.
  - S_DRAIN: lasts 2 cycles to flush the pipeline, then -> S_IDLE.
  - i_start is ignored outside S_IDLE.
- Pipeline, with i_start sampled at edge 0:
  - cycles 1..64: issue addresses 0..63
  - cycle 2 onward: RAM data returns
  - data is multiplied and registered
  - o_valid is high in cycles 3..66 with o_addr = 0..63 in order
  - o_done=1 in cycle 66
  - o_busy is high in cycles 1..66
  - Latency from address issue to o_valid is 2 cycles.
  - No backpressure: the downstream consumer must accept every valid row.
- Arithmetic, per lane:
  - out = sign_extend(q, DW) * sf, with q a signed INT4 in [-8,7] and sf a DW-bit unsigned value.
  - The product is truncated to the low DW bits as two's complement.
  - No saturation, no rounding.
  - q=0 gives exactly 0.
- Scale-factor register:
  - Loaded from i_sf_data on a clock edge where i_sf_we=1 and state==S_IDLE.
  - i_sf_we while o_busy=1 is ignored, so a pass always uses one consistent sf set.
  - If i_sf_we and i_start are asserted in the same S_IDLE cycle, the new sf is used for that pass.
- o_data holds its last value when o_valid=0. o_addr resets to 0.
- Back-to-back passes: the earliest next i_start is accepted in cycle 67 (first S_IDLE cycle). No overlap of passes.

Test Plan:
1. Reset then idle: 10 cycles with no start -> o_busy, o_valid, o_ram_re, o_done all 0; o_ram_addr=0.
2. Unity scale:
   - Stimulus: sf all lanes = 40'h400 (1.0); RAM row r lane k holds (r+k)%16 as INT4; i_start.
   - Response: 64 rows, o_addr 0..63 in cycles 3..66, o_done only in cycle 66.
   - Value checks: row 0 lane 9 (q=9 -> -7) = 40'hFFFFFFE400; row 0 lane 7 (q=7) = 40'h1C00.
3. Extremes: sf=40'h1234, q=-8 -> 40'hFFFFFF6E60; q=7 -> 40'h7F6C; q=0 -> 0.
4. sf write protection: i_sf_we with a new sf at cycle 20 of a pass -> all 64 rows use the old sf; the next pass without i_sf_we also uses the old sf.
5. Start handling:
   - i_start held high continuously -> passes start at cycles 1, 68, 135; o_busy drops for exactly one cycle between passes.
   - i_start pulsed at cycle 30 -> ignored.
6. Reset mid-pass: assert i_rst_n=0 at cycle 40 -> all outputs 0 immediately; after release, i_start gives a full clean 64-row pass with sf=0, so all o_data=0.

Source files
------------

// File: rtl/dequantize_if.sv
// Row streams around the dequantize block: quantized RAM read port and the
// reconstructed Q30.10 output stream.
interface dequantize_if #(
  parameter int LANES = 16,
  parameter int DW    = 40,
  parameter int QW    = 4,
  parameter int AW    = 6
);
  logic                  o_ram_re;
  logic [AW-1:0]         o_ram_addr;
  logic [LANES*QW-1:0]   i_ram_data;
  logic                  o_valid;
  logic [LANES*DW-1:0]   o_data;
  logic [AW-1:0]         o_addr;
  logic                  o_done;
  logic                  o_busy;

  modport master (
    output o_ram_re, o_ram_addr, o_valid, o_data, o_addr, o_done, o_busy,
    input  i_ram_data
  );

  modport slave (
    input  o_ram_re, o_ram_addr, o_valid, o_data, o_addr, o_done, o_busy,
    output i_ram_data
  );
endinterface

// File: rtl/dequantize.sv
// INT4 -> Q30.10 dequantizer: streams one 64-row block from the quantized RAM,
// scaling each lane by a per-lane factor latched while idle.
module dequantize #(
  parameter int LANES = 16,
  parameter int DW    = 40,
  parameter int QW    = 4,
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_start,
  input  logic                i_sf_we,
  input  logic [LANES*DW-1:0] i_sf_data,
  dequantize_if.master        bus
);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN} state_e;

  localparam logic [AW-1:0] LAST_ROW = AW'(DEPTH - 1);

  state_e              state_q, state_d;
  logic [AW-1:0]       rd_cnt_q, rd_cnt_d;
  logic                drain_cnt_q, drain_cnt_d;
  logic [LANES*DW-1:0] sf_q, sf_d;
  // Stage 1 tracks the read issued last cycle, whose data is on i_ram_data now.
  logic                vld1_q, vld1_d;
  logic [AW-1:0]       addr1_q, addr1_d;
  logic                valid_q, valid_d;
  logic                done_q, done_d;
  logic [AW-1:0]       addr_q, addr_d;
  logic [LANES*DW-1:0] data_q, data_d;
  logic [LANES*DW-1:0] prod;

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_d     = state_q;
    rd_cnt_d    = rd_cnt_q;
    drain_cnt_d = drain_cnt_q;
    sf_d        = sf_q;
    unique case (state_q)
      S_IDLE: begin
        if (i_sf_we) sf_d = i_sf_data;
        if (i_start) begin
          state_d  = S_READ;
          rd_cnt_d = '0;
        end
      end
      S_READ: begin
        rd_cnt_d = rd_cnt_q + 1'b1;
        if (rd_cnt_q == LAST_ROW) begin
          state_d     = S_DRAIN;
          drain_cnt_d = 1'b0;
        end
      end
      S_DRAIN: begin
        drain_cnt_d = 1'b1;
        if (drain_cnt_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Sign-extend q to DW bits; the DW x DW product truncated to DW bits is the
  // two's-complement result of signed q times unsigned sf.
  for (genvar k = 0; k < LANES; k++) begin : g_lane
    logic [QW-1:0] q;
    logic [DW-1:0] q_ext;
    assign q     = bus.i_ram_data[k*QW +: QW];
    assign q_ext = {{(DW-QW){q[QW-1]}}, q};
    assign prod[k*DW +: DW] = q_ext * sf_q[k*DW +: DW];
  end

  always_comb begin
    vld1_d  = (state_q == S_READ);
    addr1_d = rd_cnt_q;
    valid_d = vld1_q;
    done_d  = vld1_q && (addr1_q == LAST_ROW);
    addr_d  = vld1_q ? addr1_q : addr_q;
    data_d  = vld1_q ? prod : data_q;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= S_IDLE;
      rd_cnt_q    <= '0;
      drain_cnt_q <= 1'b0;
      sf_q        <= '0;
      vld1_q      <= 1'b0;
      addr1_q     <= '0;
      valid_q     <= 1'b0;
      done_q      <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
    end else begin
      state_q     <= state_d;
      rd_cnt_q    <= rd_cnt_d;
      drain_cnt_q <= drain_cnt_d;
      sf_q        <= sf_d;
      vld1_q      <= vld1_d;
      addr1_q     <= addr1_d;
      valid_q     <= valid_d;
      done_q      <= done_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
    end
  end

  assign bus.o_ram_re   = (state_q == S_READ);
  assign bus.o_ram_addr = (state_q == S_READ) ? rd_cnt_q : '0;
  assign bus.o_busy     = (state_q != S_IDLE);
  assign bus.o_valid    = valid_q;
  assign bus.o_done     = done_q;
  assign bus.o_addr     = addr_q;
  assign bus.o_data     = data_q;

endmodule

// File: tb/tb_dequantize.sv
// Self-checking bench for dequantize: random and directed passes compared
// against an arithmetic reference of q * sf per lane.
module tb_dequantize;
  localparam int LANES = 16;
  localparam int DW    = 40;
  localparam int QW    = 4;
  localparam int DEPTH = 64;
  localparam int AW    = 6;
  localparam int RW    = LANES*DW;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic          sf_we;
  logic [RW-1:0] sf_data;

  int total = 0;
  int bad   = 0;

  logic [RW-1:0]       model_sf;
  logic [LANES*QW-1:0] ram [DEPTH];
  logic [RW-1:0]       got [DEPTH];

  dequantize_if #(.LANES(LANES), .DW(DW), .QW(QW), .AW(AW)) bus ();

  dequantize #(.LANES(LANES), .DW(DW), .QW(QW), .DEPTH(DEPTH), .AW(AW)) dut (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_start   (start),
    .i_sf_we   (sf_we),
    .i_sf_data (sf_data),
    .bus       (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read RAM: data appears one cycle after the read enable.
  always @(posedge clk) begin
    if (bus.o_ram_re) bus.i_ram_data <= ram[bus.o_ram_addr];
  end

  task automatic check(input string tag, input logic [RW-1:0] obs, input logic [RW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [RW-1:0] exp_row(input int r);
    logic [RW-1:0]       row;
    logic [LANES*QW-1:0] rr;
    logic signed [QW-1:0] qv;
    longint              qi, si, p;
    row = '0;
    rr  = ram[r];
    for (int k = 0; k < LANES; k++) begin
      qv = rr[k*QW +: QW];
      qi = longint'(qv);
      si = longint'({24'd0, model_sf[k*DW +: DW]});
      p  = qi * si;
      row[k*DW +: DW] = p[DW-1:0];
    end
    return row;
  endfunction

  function automatic logic [RW-1:0] rand_sf();
    logic [RW-1:0] v;
    logic [63:0]   t;
    for (int k = 0; k < LANES; k++) begin
      t = {$urandom, $urandom};
      v[k*DW +: DW] = t[DW-1:0];
    end
    return v;
  endfunction

  function automatic logic [RW-1:0] const_sf(input logic [DW-1:0] s);
    logic [RW-1:0] v;
    for (int k = 0; k < LANES; k++) v[k*DW +: DW] = s;
    return v;
  endfunction

  task automatic rand_ram();
    for (int r = 0; r < DEPTH; r++) ram[r] = {$urandom, $urandom};
  endtask

  // phase 1..67 within a pass: 1..64 read, 65..66 drain, 67 idle.
  task automatic check_cycle(input string label, input int phase);
    logic ev;
    ev = (phase >= 3) && (phase <= 66);
    check($sformatf("%s busy p%0d", label, phase), RW'(bus.o_busy), RW'(phase <= 66));
    check($sformatf("%s ram_re p%0d", label, phase), RW'(bus.o_ram_re), RW'(phase <= 64));
    check($sformatf("%s ram_addr p%0d", label, phase), RW'(bus.o_ram_addr),
          (phase <= 64) ? RW'(phase - 1) : '0);
    check($sformatf("%s valid p%0d", label, phase), RW'(bus.o_valid), RW'(ev));
    check($sformatf("%s done p%0d", label, phase), RW'(bus.o_done), RW'(phase == 66));
    if (ev) begin
      check($sformatf("%s addr p%0d", label, phase), RW'(bus.o_addr), RW'(phase - 3));
      check($sformatf("%s data row%0d", label, phase - 3), bus.o_data, exp_row(phase - 3));
      got[phase - 3] = bus.o_data;
    end
  endtask

  // Called on a negedge in idle; i_start is sampled on the next rising edge.
  task automatic run_pass(input string label, input int sf_we_cyc,
                          input logic [RW-1:0] sf_new, input int start_cyc);
    start = 1'b1;
    for (int n = 1; n <= 67; n++) begin
      @(negedge clk);
      start = 1'b0;
      sf_we = 1'b0;
      check_cycle(label, n);
      if (n == sf_we_cyc) begin
        sf_we   = 1'b1;
        sf_data = sf_new;
      end
      if (n == start_cyc) start = 1'b1;
    end
  endtask

  task automatic load_sf(input logic [RW-1:0] v);
    sf_data  = v;
    sf_we    = 1'b1;
    @(negedge clk);
    sf_we    = 1'b0;
    model_sf = v;
  endtask

  initial begin
    logic [RW-1:0] row;
    logic [RW-1:0] sf_a;
    logic [LANES*QW-1:0] rr;

    rst_n    = 1'b0;
    start    = 1'b0;
    sf_we    = 1'b0;
    sf_data  = '0;
    model_sf = '0;
    for (int r = 0; r < DEPTH; r++) ram[r] = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Idle after reset.
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      check_cycle("idle", 67);
      check("idle data", bus.o_data, '0);
      check("idle addr", RW'(bus.o_addr), '0);
    end

    // Unity scale, row r lane k = (r+k)%16.
    for (int r = 0; r < DEPTH; r++)
      for (int k = 0; k < LANES; k++) begin
        rr = ram[r];
        rr[k*QW +: QW] = QW'((r + k) % 16);
        ram[r] = rr;
      end
    load_sf(const_sf(40'h400));
    run_pass("unity", 0, '0, 0);
    row = got[0];
    check("unity r0 lane9", RW'(row[9*DW +: DW]), RW'(40'hFFFFFFE400));
    check("unity r0 lane7", RW'(row[7*DW +: DW]), RW'(40'h1C00));

    // Extremes: q = -8, 7, 0 with sf 0x1234.
    rand_ram();
    rr = ram[5];
    rr[0*QW +: QW] = 4'h8;
    rr[1*QW +: QW] = 4'h7;
    rr[2*QW +: QW] = 4'h0;
    ram[5] = rr;
    load_sf(const_sf(40'h1234));
    run_pass("extreme", 0, '0, 0);
    row = got[5];
    check("extreme q=-8", RW'(row[0*DW +: DW]), RW'(40'hFFFFFF6E60));
    check("extreme q=7",  RW'(row[1*DW +: DW]), RW'(40'h7F6C));
    check("extreme q=0",  RW'(row[2*DW +: DW]), '0);

    // Random data; sf write coincident with start applies to this pass.
    rand_ram();
    sf_a     = rand_sf();
    sf_data  = sf_a;
    sf_we    = 1'b1;
    model_sf = sf_a;
    run_pass("rand_same_cycle", 0, '0, 0);

    // sf writes while busy are ignored, also for the following pass.
    rand_ram();
    load_sf(rand_sf());
    run_pass("sf_protect", 20, rand_sf(), 0);
    run_pass("sf_keep", 0, '0, 0);

    // A start pulse mid-pass is ignored.
    rand_ram();
    run_pass("start_pulse", 0, '0, 30);
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      check_cycle("post_pulse_idle", 67);
    end

    // Start held high: passes back-to-back with a single idle cycle between.
    start = 1'b1;
    for (int n = 1; n <= 201; n++) begin
      @(negedge clk);
      check_cycle("continuous", ((n - 1) % 67) + 1);
      if (n == 201) start = 1'b0;
    end
    @(negedge clk);
    check_cycle("continuous_end", 67);

    // Reset mid-pass clears everything including sf.
    start = 1'b1;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      start = 1'b0;
      check_cycle("pre_reset", n);
    end
    rst_n = 1'b0;
    #1;
    check("rst busy", RW'(bus.o_busy), '0);
    check("rst valid", RW'(bus.o_valid), '0);
    check("rst done", RW'(bus.o_done), '0);
    check("rst ram_re", RW'(bus.o_ram_re), '0);
    check("rst ram_addr", RW'(bus.o_ram_addr), '0);
    check("rst addr", RW'(bus.o_addr), '0);
    check("rst data", bus.o_data, '0);
    model_sf = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    rand_ram();
    run_pass("after_reset", 0, '0, 0);
    for (int r = 0; r < DEPTH; r += 21)
      check($sformatf("after_reset zero row%0d", r), got[r], '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
